// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage holding the PC plus a DEPTH-entry queue of
// {pc, instr} pairs that decode drains over a valid/ready handshake.
module fetch_queue #(
  parameter int          N        = 64,
  parameter int          IW       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int          INC      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc_F,
  input  logic [N-1:0]               PCBranch_F,
  output logic [N-1:0]               imem_addr_F,
  input  logic [IW-1:0]              imem_data_F,
  input  logic                       imem_ready_F,
  output logic                       imem_en_F,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [IW-1:0]              instr_D,
  output logic [N-1:0]               pc_D,
  output logic [$clog2(DEPTH+1)-1:0] count_F
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be in 1..16");
  end

  logic [N-1:0]  pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  ent_pc   [DEPTH];
  logic [IW-1:0] ent_instr[DEPTH];

  logic push;
  logic pop;
  logic has_room;

  // explicit wrap so non-power-of-two depths stay in range
  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign has_room = (count_q != FULL);

  // gated by PCSrc_F so decode never takes a wrong-path entry
  assign valid_D = (count_q != '0) & ~PCSrc_F;
  assign pop     = valid_D & ready_D;
  assign push    = ~PCSrc_F & imem_ready_F
                 & (has_room | pop);

  assign imem_en_F   = push;
  assign imem_addr_F = pc_q;
  assign count_F     = count_q;
  assign instr_D     = ent_instr[head_q];
  assign pc_D        = ent_pc[head_q];

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (PCSrc_F) begin
      pc_d    = PCBranch_F;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + N'(INC);
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ent_pc[tail_q]    <= pc_q;
      ent_instr[tail_q] <= imem_data_F;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= FULL);
      assert (!(pop && count_q == '0));
      assert (!(push && !pop && !has_room));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue (DEPTH 4 and 1)
// against an occupancy/PC reference model.
module tb_fetch_queue;

  localparam int N   = 64;
  localparam int IW  = 32;
  localparam int INC = 4;
  localparam logic [N-1:0] RPC = '0;

  logic          clk = 1'b0;
  logic          reset, pcsrc, ir, rd;
  logic [N-1:0]  br;

  logic [N-1:0]  addr_a, addr_b, pcd_a, pcd_b;
  logic [IW-1:0] data_a, data_b, ins_a, ins_b;
  logic          en_a, en_b, val_a, val_b;
  logic [2:0]    cnt_a;
  logic [0:0]    cnt_b;

  int tests  = 0;
  int failed = 0;

  // reference model: queue is always the cnt PCs just below pc
  logic [N-1:0] mpc [2];
  int           mcnt[2];
  int           dep [2];

  logic [N-1:0] e_addr[2];
  logic [N-1:0] e_pc  [2];
  logic         e_val [2];
  logic         e_en  [2];
  logic         e_pop [2];
  int           e_cnt [2];

  logic [N-1:0]  o_addr[2];
  logic [N-1:0]  o_pc  [2];
  logic [IW-1:0] o_ins [2];
  logic          o_val [2];
  logic          o_en  [2];
  logic [2:0]    o_cnt [2];

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem(input logic [N-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  assign data_a = mem(addr_a);
  assign data_b = mem(addr_b);

  fetch_queue #(.N(N), .IW(IW), .DEPTH(4), .RESET_PC(RPC), .INC(INC)) u_a (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(br),
    .imem_addr_F(addr_a), .imem_data_F(data_a), .imem_ready_F(ir),
    .imem_en_F(en_a), .valid_D(val_a), .ready_D(rd),
    .instr_D(ins_a), .pc_D(pcd_a), .count_F(cnt_a)
  );

  fetch_queue #(.N(N), .IW(IW), .DEPTH(1), .RESET_PC(RPC), .INC(INC)) u_b (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(br),
    .imem_addr_F(addr_b), .imem_data_F(data_b), .imem_ready_F(ir),
    .imem_en_F(en_b), .valid_D(val_b), .ready_D(rd),
    .instr_D(ins_b), .pc_D(pcd_b), .count_F(cnt_b)
  );

  assign o_addr[0] = addr_a;
  assign o_addr[1] = addr_b;
  assign o_pc[0]   = pcd_a;
  assign o_pc[1]   = pcd_b;
  assign o_ins[0]  = ins_a;
  assign o_ins[1]  = ins_b;
  assign o_val[0]  = val_a;
  assign o_val[1]  = val_b;
  assign o_en[0]   = en_a;
  assign o_en[1]   = en_b;
  assign o_cnt[0]  = cnt_a;
  assign o_cnt[1]  = {2'b00, cnt_b};

  // drive inputs after the falling edge, then compute expectations
  task automatic apply(input logic r, input logic ps,
                       input logic [N-1:0] b,
                       input logic i, input logic d);
    reset = r;
    pcsrc = ps;
    br    = b;
    ir    = i;
    rd    = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      e_val[k]  = (mcnt[k] != 0) && !ps;
      e_pop[k]  = e_val[k] && d;
      e_en[k]   = !ps && i && ((mcnt[k] < dep[k]) || e_pop[k]);
      e_addr[k] = mpc[k];
      e_cnt[k]  = mcnt[k];
      e_pc[k]   = mpc[k] - N'(INC * mcnt[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mpc[k]  = RPC;
        mcnt[k] = 0;
      end else if (pcsrc) begin
        mpc[k]  = br;
        mcnt[k] = 0;
      end else begin
        if (e_en[k]) begin
          mpc[k]  = mpc[k] + N'(INC);
          mcnt[k] = mcnt[k] + 1;
        end
        if (e_pop[k]) mcnt[k] = mcnt[k] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (addr_a !== RPC) begin
      failed++; $display("FAIL reset_addr: got %h want %h", addr_a, RPC);
    end
    tests++;
    if (val_a !== 1'b0 || val_b !== 1'b0) begin
      failed++; $display("FAIL reset_valid: got %b/%b want 0/0", val_a, val_b);
    end
    tests++;
    if (cnt_a !== 3'd0 || cnt_b !== 1'b0) begin
      failed++; $display("FAIL reset_count: got %0d/%0d want 0/0", cnt_a, cnt_b);
    end
    tests++;
    if (en_a !== 1'b1) begin
      failed++; $display("FAIL reset_en: got %b want 1", en_a);
    end
    tick();
    apply(1'b1, 1'b1, '0, 1'b1, 1'b0);
    tests++;
    if (en_a !== 1'b0) begin
      failed++; $display("FAIL reset_en_redirect: got %b want 0", en_a);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [N-1:0] hp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
      hp = N'(4 * (i - 1));
      tests++;
      if (addr_a !== N'(4 * i) || en_a !== 1'b1) begin
        failed++;
        $display("FAIL stream_addr[%0d]: got %h en %b want %h en 1", i, addr_a, en_a, N'(4 * i));
      end
      tests++;
      if (val_a !== (i != 0)) begin
        failed++; $display("FAIL stream_valid[%0d]: got %b want %b", i, val_a, i != 0);
      end
      if (i != 0) begin
        tests++;
        if (pcd_a !== hp || ins_a !== mem(hp)) begin
          failed++;
          $display("FAIL stream_head[%0d]: got %h/%h want %h/%h", i, pcd_a, ins_a, hp, mem(hp));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int f;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      f = (i < 4) ? i : 4;
      tests++;
      if (cnt_a !== 3'(f) || en_a !== (i < 4) || addr_a !== N'(4 * f)) begin
        failed++;
        $display("FAIL bp_fill[%0d]: got cnt %0d en %b addr %h want %0d %b %h",
                 i, cnt_a, en_a, addr_a, f, i < 4, N'(4 * f));
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
      tests++;
      if (val_a !== 1'b1 || pcd_a !== N'(4 * i) || cnt_a !== 3'd4 || en_a !== 1'b1) begin
        failed++;
        $display("FAIL bp_drain[%0d]: got v %b pc %h cnt %0d en %b want 1 %h 4 1",
                 i, val_a, pcd_a, cnt_a, en_a, N'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    apply(1'b0, 1'b1, N'(64'h400), 1'b1, 1'b1);
    tests++;
    if (val_a !== 1'b0 || en_a !== 1'b0 || addr_a !== N'(64'hC) || cnt_a !== 3'd3) begin
      failed++;
      $display("FAIL redir_pulse: got v %b en %b addr %h cnt %0d want 0 0 c 3",
               val_a, en_a, addr_a, cnt_a);
    end
    tick();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tests++;
    if (cnt_a !== 3'd0 || addr_a !== N'(64'h400) || val_a !== 1'b0) begin
      failed++;
      $display("FAIL redir_next: got cnt %0d addr %h v %b want 0 400 0", cnt_a, addr_a, val_a);
    end
    tick();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tests++;
    if (val_a !== 1'b1 || pcd_a !== N'(64'h400) || ins_a !== mem(N'(64'h400))) begin
      failed++;
      $display("FAIL redir_target: got v %b pc %h want 1 400", val_a, pcd_a);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [3:0] pat;
    logic [N-1:0] nxt;
    pat = 4'b1001;
    nxt = RPC;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b0, '0, pat[i % 4], 1'b1);
      tests++;
      if (addr_a !== nxt || en_a !== pat[i % 4]) begin
        failed++;
        $display("FAIL wait_pc[%0d]: got %h en %b want %h en %b", i, addr_a, en_a, nxt, pat[i % 4]);
      end
      tests++;
      if (val_a !== e_val[0] || (e_val[0] && pcd_a !== e_pc[0])) begin
        failed++;
        $display("FAIL wait_head[%0d]: got v %b pc %h want v %b pc %h",
                 i, val_a, pcd_a, e_val[0], e_pc[0]);
      end
      if (pat[i % 4]) nxt = nxt + N'(INC);
      tick();
    end
  endtask

  task automatic test_depth1();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (i != 0) begin
        tests++;
        if (cnt_b !== 1'b1 || val_b !== 1'b1 || en_b !== 1'b1
            || pcd_b !== N'(4 * (i - 1)) || ins_b !== mem(N'(4 * (i - 1)))) begin
          failed++;
          $display("FAIL depth1[%0d]: got cnt %0d v %b en %b pc %h want 1 1 1 %h",
                   i, cnt_b, val_b, en_b, pcd_b, N'(4 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] w;
    w = '1 - N'(3);
    do_reset();
    apply(1'b0, 1'b1, w, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
      tests++;
      if (addr_a !== w + N'(4 * i)) begin
        failed++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_a, w + N'(4 * i));
      end
      if (i != 0) begin
        tests++;
        if (val_a !== 1'b1 || pcd_a !== w + N'(4 * (i - 1))) begin
          failed++;
          $display("FAIL wrap_head[%0d]: got v %b pc %h want 1 %h", i, val_a, pcd_a, w + N'(4 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    apply(1'b1, 1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (cnt_a !== 3'd4) begin
      failed++; $display("FAIL midreset_full: got %0d want 4", cnt_a);
    end
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests++;
    if (cnt_a !== 3'd0 || val_a !== 1'b0 || addr_a !== RPC) begin
      failed++;
      $display("FAIL midreset_after: got cnt %0d v %b addr %h want 0 0 %h", cnt_a, val_a, addr_a, RPC);
    end
    tick();
  endtask

  task automatic test_random();
    logic r, ps, i, d;
    logic [N-1:0] b;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom % 40) == 0;
      ps = ($urandom % 6) == 0;
      b  = {$urandom, $urandom};
      if ($urandom % 2) b[1:0] = 2'b00;
      if ($urandom % 8 == 0) b = '1 - N'(4 * ($urandom % 3));
      i  = ($urandom % 4) != 0;
      d  = ($urandom % 3) != 0;
      apply(r, ps, b, i, d);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (o_addr[k] !== e_addr[k] || o_en[k] !== e_en[k]
            || o_val[k] !== e_val[k] || o_cnt[k] !== 3'(e_cnt[k])) begin
          failed++;
          $display("FAIL rand_ctl[%0d/%0d]: got a %h en %b v %b c %0d want %h %b %b %0d",
                   c, k, o_addr[k], o_en[k], o_val[k], o_cnt[k],
                   e_addr[k], e_en[k], e_val[k], e_cnt[k]);
        end
        if (e_val[k]) begin
          tests++;
          if (o_pc[k] !== e_pc[k] || o_ins[k] !== mem(e_pc[k])) begin
            failed++;
            $display("FAIL rand_head[%0d/%0d]: got %h/%h want %h/%h",
                     c, k, o_pc[k], o_ins[k], e_pc[k], mem(e_pc[k]));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    dep[0]  = 4;
    dep[1]  = 1;
    mpc[0]  = RPC;
    mpc[1]  = RPC;
    mcnt[0] = 0;
    mcnt[1] = 0;
    reset   = 1'b1;
    pcsrc   = 1'b0;
    br      = '0;
    ir      = 1'b0;
    rd      = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_mem_wait();
    test_depth1();
    test_wrap();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling queue between fetch and decode. It holds the PC, drives the instruction-memory address, and pushes {PC, instruction} pairs into a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A taken branch (PCSrc_F) redirects the PC and flushes the queue. It replaces the single-register fetch stage in the pipelined datapath. Decode stalls and memory wait cycles no longer need to freeze the whole front end.

## Interface
- N, 64, address/PC width
- IW, 32, instruction width
- DEPTH, 4, queue entries; legal range 1..16
- RESET_PC, 0, PC value loaded on reset
- INC, 4, sequential PC increment
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears PC to RESET_PC and empties the queue
- PCSrc_F  in  1  redirect request; when 1, PC takes PCBranch_F and the queue is flushed
- PCBranch_F  in  N  redirect target
- imem_addr_F  out  N  instruction-memory address, equals the PC register
- imem_data_F  in  IW  instruction at imem_addr_F; combinational, valid in the same cycle when imem_ready_F=1
- imem_ready_F  in  1  memory has valid data this cycle; 0 means wait
- imem_en_F  out  1  a fetch (queue push) is committed this cycle
- valid_D  out  1  queue head is valid for decode
- ready_D  in  1  decode accepts the head this cycle
- instr_D  out  IW  head instruction
- pc_D  out  N  PC of the head instruction
- count_F  out  $clog2(DEPTH+1)  current occupancy (debug/perf)

## Operation
- State consists of:
  - PC register (N bits).
  - Circular buffer of DEPTH entries {pc, instr}.
  - Head and tail pointers, each $clog2(DEPTH) bits (minimum 1).
  - Occupancy counter.
- pop = valid_D & ready_D.
- push = imem_en_F = !PCSrc_F & imem_ready_F & (count < DEPTH | pop).
- valid_D = (count != 0) & !PCSrc_F. This is combinational on PCSrc_F so decode never consumes a younger instruction in the redirect cycle.
- instr_D and pc_D are read combinationally from the head entry. Their values are don't-care when valid_D=0.
- Priority per cycle is reset, then redirect, then normal.
  - **Reset:** PC ← RESET_PC, count ← 0, head ← 0, tail ← 0.
  - **Redirect (PCSrc_F=1):**
    - PC ← PCBranch_F.
    - count ← 0 and head ← tail. The memory contents are left unchanged.
    - No push and no pop.
    - PCBranch_F is taken verbatim; it is not realigned.
  - **Normal:**
    - On push: entry[tail] ← {PC, imem_data_F}, tail increments, and PC ← PC + INC (mod 2^N, so it wraps silently at the top of the address space).
    - On pop: head increments.
    - Counter: count +1 on push only, −1 on pop only, unchanged on both or neither.
    - Without push, the PC holds.
- Pointers wrap modulo DEPTH. Non-power-of-two DEPTH is legal; pointers wrap explicitly at DEPTH−1.
- **Full queue:** count=DEPTH. A push happens only if a pop occurs in the same cycle; otherwise the PC holds and imem_en_F=0.
- **Empty queue:** valid_D=0. ready_D is ignored.
- **Memory wait:** imem_ready_F=0 means no push and the PC holds. Pops continue.
- **Assertions (simulation only):** the counter never exceeds DEPTH and never underflows.

## Timing
- Reset values:
  - imem_addr_F = RESET_PC
  - valid_D = 0
  - count_F = 0
  - imem_en_F = imem_ready_F & !PCSrc_F, because the queue is empty.
- **Fetch-to-decode latency:** an instruction pushed at edge t is visible with valid_D=1 in the cycle after edge t. Minimum latency is 1 cycle.
- **Throughput:** 1 instruction/cycle sustained for any DEPTH ≥ 1 while imem_ready_F=1 and ready_D=1, because push and pop are allowed in the same cycle when full.
- **Redirect:**
  - In the cycle of PCSrc_F, imem_addr_F still shows the old PC.
  - In the next cycle, imem_addr_F = PCBranch_F and valid_D=0.
  - The first target instruction reaches decode 2 cycles after the redirect cycle. That is 1 cycle for the PC update plus 1 cycle for the queue.
- **Back-to-back redirects:** each one overrides the previous; only the last target survives.
- **Reset mid-operation:** a reset asserted while the queue is full behaves exactly like power-on reset on the next edge. No stale entry is ever presented.
- The only combinational paths from input to output are:
  - PCSrc_F → valid_D
  - PCSrc_F, imem_ready_F, ready_D → imem_en_F

## Test plan
- **Reset and streaming:** reset, then RESET_PC=0, imem_ready_F=1, ready_D=1. Required response:
  - imem_addr_F steps 0, 4, 8, …
  - pc_D = 0 is first seen 1 cycle after reset deasserts.
  - instr_D matches memory at every address.
  - valid_D stays 1 continuously, i.e. 1 instruction per cycle.
- **Fill and backpressure:** DEPTH=4, ready_D=0 for 8 cycles. Required response:
  - count_F reaches 4, then imem_en_F=0 and imem_addr_F is frozen at 0x10.
  - After ready_D=1, the heads are 0, 4, 8, 0xC, then 0x10 with no gap.
- **Redirect flush:** with the queue holding 3 entries, pulse PCSrc_F with PCBranch_F=0x400. Required response:
  - valid_D=0 in the pulse cycle.
  - count_F=0 next cycle and imem_addr_F=0x400.
  - pc_D=0x400 two cycles after the pulse.
  - No old entry reaches decode.
- **Memory wait:** toggle imem_ready_F as 1,0,0,1. Required response:
  - PC advances only in the ready cycles.
  - The queue receives consecutive PCs with no duplicate or skipped entry.
- **Full with simultaneous push and pop, DEPTH=1:** ready_D=1 and imem_ready_F=1. Required response: count_F stays at 1 and pc_D advances by 4 every cycle.
- **Wraparound and mid-stream reset:**
  - PCBranch_F = 2^N−4. Required response: the fetched sequence is 2^N−4 then 0.
  - Assert reset with the queue full. Required response: next cycle count_F=0, valid_D=0, imem_addr_F=RESET_PC.
